mul_div_unit: RTL

//   Iterative unsigned multiply/divide unit in the EX stage, beside the 32-bit ALU.

---
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative unsigned multiply/divide unit that sits beside the EX-stage ALU.
//   MULTU uses shift-add and DIVU uses restoring division. Each one runs for
//   WIDTH cycles. The results are held in the HI/LO registers, which the EX
//   result mux reads for MFHI/MFLO. MTHI/MTLO write HI/LO directly in one edge.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request; sampled only while idle
//   op           in   00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
//   DataA        in   multiplicand / dividend / MTHI-MTLO source (rs)
//   DataB        in   multiplier / divisor (rt)
//   busy         out  high while an iteration sequence is running
//   done         out  one-cycle pulse when Hi/Lo hold a new MULTU/DIVU result
//   div_by_zero  out  valid with done; the finished DIVU had a zero divisor
//   Hi, Lo       out  HI / LO registers
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV)
  logic [2*WIDTH-1:0] acc;       // MUL: {partial, multiplier}; DIV: {rem, quot}
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;   // {remainder, next dividend bit}
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic               last;

  assign last = (cnt == CW'(WIDTH - 1));

  // One iteration step for each algorithm.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    ge       = (shifted >= {1'b0, opnd});
    // When ge is set, the difference fits in WIDTH bits, so the modulo
    // subtract gives the exact value.
    diff     = shifted[WIDTH-1:0] - opnd;
    acc_next = acc;
    case (state)
      // The multiplier LSB decides the add. The carry is shifted in at the top.
      MUL: acc_next = {mul_sum, acc[WIDTH-1:1]};
      // The quotient bit shifts in at the bottom. The divisor is subtracted
      // only when it fits.
      DIV: acc_next = ge ? {diff, acc[WIDTH-2:0], 1'b1}
                         : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      default: acc_next = acc;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && op == 2'b00) state_next = MUL;
        if (start && op == 2'b01) state_next = DIV;
      end
      MUL, DIV: if (last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so all registers
  // update together at the edge, whatever order they are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well. An abort then leaves
      // no stale partial result behind, and the state after reset is fully
      // defined.
      cnt         <= '0;
      opnd        <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Hi          <= '0;
      Lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              2'b00: begin
                acc  <= {{WIDTH{1'b0}}, DataB};
                opnd <= DataA;
                cnt  <= '0;
                busy <= 1'b1;
              end
              2'b01: begin
                acc  <= {{WIDTH{1'b0}}, DataA};
                opnd <= DataB;
                cnt  <= '0;
                busy <= 1'b1;
              end
              2'b10:   Hi <= DataA;
              default: Lo <= DataA;
            endcase
          end
        end
        default: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            Hi          <= acc_next[2*WIDTH-1:WIDTH];
            Lo          <= acc_next[WIDTH-1:0];
            div_by_zero <= (state == DIV) && (opnd == '0);
          end
        end
      endcase
    end
  end

endmodule
